scalar_bitcount_unit: RTL and testbench
=======================================

# scalar_bitcount_unit

Parametrised successor to the scalar pop-count / leading-zero unit. Executes population count, leading-zero count, trailing-zero count and parity on one S-register operand and returns a zero-extended count tagged with its destination A-register address. It adds a valid/destination pipeline, reset, a structural-hazard stall for mixed-latency ops, and width/latency generics. It sits beside the other scalar functional units and feeds the A-register write port.

## Interface
- DATA_W, 64: operand width; power of two, ≥ 16.
- GROUP_W, 8: first-level group width; power of two dividing DATA_W.
- RES_W, 24: result width (A-register width); ≥ CW = log2(DATA_W)+1.
- DEST_W, 3: destination register address width.
- POP_LAT, 4: pop-count latency in cycles; POP_LAT > SHORT_LAT.
- SHORT_LAT, 3: LZ/TZ/parity latency in cycles; ≥ 2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  issue strobe.
- i_op  in  2  00 POP, 01 LZ, 10 TZ, 11 PARITY.
- i_sj  in  DATA_W  operand.
- i_dest  in  DEST_W  destination A-register address.
- o_short_ready  out  1  short ops (LZ/TZ/PARITY) may be issued this cycle.
- o_valid  out  1  result strobe, one cycle per accepted op.
- o_result  out  RES_W  result, zero-extended.
- o_dest  out  DEST_W  destination address of o_result.

## Operation
- Accept: i_valid && (i_op==POP || o_short_ready). POP always accepted.
- Short op presented while o_short_ready=0: not accepted, no result ever produced, no other state changes.
- POP: count of 1 bits, 0..DATA_W.
- LZ: zeros above the most significant 1; operand 0 -> DATA_W.
- TZ: zeros below the least significant 1; operand 0 -> DATA_W.
- PARITY: XOR of all bits in result bit 0, upper bits 0.
- All counts CW bits, bits RES_W-1..CW forced 0.
- Hazard: a short op accepted at t and a POP accepted at t-(POP_LAT-SHORT_LAT) would complete together; o_short_ready is low exactly in that cycle, i.e. a registered POP-issue flag delayed POP_LAT-SHORT_LAT-1 cycles, inverted. No other stall source.
- Op, dest and valid travel in a shift pipeline alongside data; results emerge strictly in completion order, never two per cycle.
- Zero-count method: per-group zero-flag and in-group count, then priority select over group flags (LZ from top group, TZ from bottom), concatenate {all-zero, group index, in-group count}.

## Timing
- Accepted at edge t -> o_valid high for the cycle after edge t+POP_LAT-1 (POP) or t+SHORT_LAT-1 (short); i.e. defaults: POP 4 cycles, short 3 cycles, matching the machine timing tables.
- Back-to-back issue every cycle sustained, subject only to the hazard rule.
- Reset: o_valid=0, o_result=0, o_dest=0, o_short_ready=1; all in-flight ops discarded; no o_valid for any op accepted before reset, even if reset spans one cycle.
- o_result/o_dest hold last value while o_valid=0 (no requirement to zero).
- o_short_ready derived from registers only, not from i_valid/i_op (no combinational path input->output).

## Configuration
- SCALAR_BITCOUNT_TZ_EN defined: TZ implemented as above.
- Undefined: TZ logic omitted; op 10 accepted as short op, returns result 0 with normal short latency and valid/dest; POP/LZ/PARITY unchanged.

## Structure
- Package cray_bitcount_pkg: op encodings (OP_POP, OP_LZ, OP_TZ, OP_PARITY), 2-bit op typedef, CW function of DATA_W.
- Sub-module bitcount_group: one GROUP_W slice -> zero flag, leading-zero count, trailing-zero count, partial pop count; instantiated DATA_W/GROUP_W times, and once more over group flags where NG ≤ GROUP_W.

## Test plan
- Reset mid-flight: POP of all-ones at t, rst pulse at t+1 -> no o_valid ever, outputs 0, o_short_ready=1.
- POP sweep: 0 -> 0, 64'hFFFF_FFFF_FFFF_FFFF -> 64, 64'h8000_0000_0000_0001 -> 2; each valid 4 cycles after issue with dest echoed.
- LZ/TZ: 64'h0000_0100_0000_0000 -> LZ 23, TZ 40; 0 -> LZ 64, TZ 64; 1 -> LZ 63, TZ 0; 3-cycle latency.
- Hazard: POP dest 1 at t, LZ dest 2 at t+1 -> o_short_ready=0 at t+1, LZ dropped, only dest 1 result; LZ retried t+2 -> result at t+4 after POP at t+3.
- Streaming: 16 alternating LZ/PARITY ops on consecutive cycles -> 16 results in order, parity of 64'h7 = 1.
- Macro off: TZ of 64'h10 -> result 0, valid at 3 cycles; macro on -> 4.

Source files
------------

// File: rtl/cray_bitcount_pkg.sv
// Shared op encodings and width helpers for the scalar bit-count unit.
package cray_bitcount_pkg;

  typedef enum logic [1:0] {
    OP_POP    = 2'b00,
    OP_LZ     = 2'b01,
    OP_TZ     = 2'b10,
    OP_PARITY = 2'b11
  } op_e;

  // Count width: wide enough to hold data_w itself (all-zero LZ/TZ, all-ones POP).
  function automatic int unsigned cw_of(int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/bitcount_group.sv
// One W-bit slice: zero flag, leading/trailing zero counts within the slice, partial pop count.
module bitcount_group #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]           x,
  output logic                   zero,
  output logic [$clog2(W)-1:0]   lz,
  output logic [$clog2(W)-1:0]   tz,
  output logic [$clog2(W):0]     pop
);

  localparam int unsigned LW = $clog2(W);
  localparam int unsigned PW = LW + 1;

  always_comb begin
    zero = ~|x;
    lz   = '0;
    tz   = '0;
    pop  = '0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < int'(W); i++) begin
      pop = pop + PW'(x[i]);
      if (x[i]) lz = LW'(int'(W) - 1 - i);
    end
    // Descending scan: the last hit is the lowest set bit.
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (x[i]) tz = LW'(i);
    end
  end

endmodule

// File: rtl/scalar_bitcount_unit.sv
// Pipelined POP/LZ/TZ/PARITY unit with destination tagging and a POP-vs-short hazard stall.
// Define SCALAR_BITCOUNT_TZ_EN to implement TZ; otherwise op 10 returns 0 at short latency.
module scalar_bitcount_unit
  import cray_bitcount_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned GROUP_W   = 8,
  parameter int unsigned RES_W     = 24,
  parameter int unsigned DEST_W    = 3,
  parameter int unsigned POP_LAT   = 4,
  parameter int unsigned SHORT_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_sj,
  input  logic [DEST_W-1:0] i_dest,
  output logic              o_short_ready,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result,
  output logic [DEST_W-1:0] o_dest
);

  localparam int unsigned CW  = cw_of(DATA_W);
  localparam int unsigned NG  = DATA_W / GROUP_W;
  localparam int unsigned GD  = POP_LAT - SHORT_LAT;  // POP-only stages ahead of the merge stage
  localparam int unsigned RD  = SHORT_LAT - 1;        // result stages after the merge stage
  localparam int unsigned GLW = $clog2(GROUP_W);
  localparam int unsigned FW  = (NG > GROUP_W) ? NG : GROUP_W;
  localparam int unsigned FLW = $clog2(FW);

  // POP-only delay line
  logic [GD-1:0]             pv_q;
  logic [GD-1:0][DATA_W-1:0] pd_q;
  logic [GD-1:0][DEST_W-1:0] pdst_q;

  logic pop_acc, short_acc;

  // A POP leaving the delay line claims the merge stage next edge; short ops must yield.
  assign o_short_ready = ~pv_q[GD-1];
  assign pop_acc       = i_valid && (i_op == OP_POP);
  assign short_acc     = i_valid && (i_op != OP_POP) && o_short_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q   <= '0;
      pd_q   <= '0;
      pdst_q <= '0;
    end else begin
      pv_q[0] <= pop_acc;
      if (pop_acc) begin
        pd_q[0]   <= i_sj;
        pdst_q[0] <= i_dest;
      end
      for (int k = 1; k < int'(GD); k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) begin
          pd_q[k]   <= pd_q[k-1];
          pdst_q[k] <= pdst_q[k-1];
        end
      end
    end
  end

  // Merge stage: POPs arrive from the delay line, short ops directly from the issue port
  logic              m_v_q, m_v_d;
  op_e               m_op_q, m_op_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DEST_W-1:0] m_dest_q, m_dest_d;

  always_comb begin
    m_v_d    = 1'b0;
    m_op_d   = m_op_q;
    m_data_d = m_data_q;
    m_dest_d = m_dest_q;
    if (pv_q[GD-1]) begin
      m_v_d    = 1'b1;
      m_op_d   = OP_POP;
      m_data_d = pd_q[GD-1];
      m_dest_d = pdst_q[GD-1];
    end else if (short_acc) begin
      m_v_d    = 1'b1;
      m_op_d   = op_e'(i_op);
      m_data_d = i_sj;
      m_dest_d = i_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_op_q   <= OP_POP;
      m_data_q <= '0;
      m_dest_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_op_q   <= m_op_d;
      m_data_q <= m_data_d;
      m_dest_q <= m_dest_d;
    end
  end

  // Group-level counts over the merge-stage operand
  logic [NG-1:0]            g_zero;
  logic [NG-1:0][GLW-1:0]   g_lz, g_tz;
  logic [NG-1:0][GLW:0]     g_pop;
  logic [FW-1:0]            f_vec;
  logic                     all_zero;
  logic [FLW-1:0]           f_lz, f_tz;
  logic [FLW:0]             unused_flag_pop;

  for (genvar g = 0; g < int'(NG); g++) begin : gen_grp
    bitcount_group #(.W(GROUP_W)) u_grp (
      .x    (m_data_q[g*GROUP_W +: GROUP_W]),
      .zero (g_zero[g]),
      .lz   (g_lz[g]),
      .tz   (g_tz[g]),
      .pop  (g_pop[g])
    );
  end

  // Second level over "group non-zero" flags gives the priority group index both ways.
  assign f_vec = FW'(~g_zero);

  bitcount_group #(.W(FW)) u_flag (
    .x    (f_vec),
    .zero (all_zero),
    .lz   (f_lz),
    .tz   (f_tz),
    .pop  (unused_flag_pop)
  );

  logic [FLW-1:0] hi_idx;
  logic [GLW-1:0] lz_sel;
  logic [CW-1:0]  pop_sum, lz_cnt, tz_cnt, res;

  always_comb begin
    hi_idx  = FLW'(FW - 1) - f_lz;
    pop_sum = '0;
    lz_sel  = '0;
    for (int g = 0; g < int'(NG); g++) begin
      pop_sum = pop_sum + CW'(g_pop[g]);
      if (FLW'(g) == hi_idx) lz_sel = g_lz[g];
    end
    // GROUP_W is a power of two, so this sum is {all-zero, group index, in-group count}.
    lz_cnt = all_zero ? CW'(DATA_W)
                      : CW'((NG - 1 - 32'(hi_idx)) * GROUP_W) + CW'(lz_sel);
  end

`ifdef SCALAR_BITCOUNT_TZ_EN
  logic [GLW-1:0] tz_sel;

  always_comb begin
    tz_sel = '0;
    for (int g = 0; g < int'(NG); g++) begin
      if (FLW'(g) == f_tz) tz_sel = g_tz[g];
    end
    tz_cnt = all_zero ? CW'(DATA_W) : CW'(32'(f_tz) * GROUP_W) + CW'(tz_sel);
  end
`else
  logic unused_tz;
  assign tz_cnt    = '0;
  assign unused_tz = ^{g_tz, f_tz};
`endif

  always_comb begin
    res = '0;
    unique case (m_op_q)
      OP_POP:    res = pop_sum;
      OP_LZ:     res = lz_cnt;
      OP_TZ:     res = tz_cnt;
      OP_PARITY: res = CW'(^m_data_q);
      default:   res = '0;
    endcase
  end

  // Result stages; data only moves with a valid token so outputs hold between results.
  logic [RD-1:0]             r_v_q;
  logic [RD-1:0][CW-1:0]     r_res_q;
  logic [RD-1:0][DEST_W-1:0] r_dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_q    <= '0;
      r_res_q  <= '0;
      r_dest_q <= '0;
    end else begin
      r_v_q[0] <= m_v_q;
      if (m_v_q) begin
        r_res_q[0]  <= res;
        r_dest_q[0] <= m_dest_q;
      end
      for (int k = 1; k < int'(RD); k++) begin
        r_v_q[k] <= r_v_q[k-1];
        if (r_v_q[k-1]) begin
          r_res_q[k]  <= r_res_q[k-1];
          r_dest_q[k] <= r_dest_q[k-1];
        end
      end
    end
  end

  assign o_valid  = r_v_q[RD-1];
  assign o_result = RES_W'(r_res_q[RD-1]);
  assign o_dest   = r_dest_q[RD-1];

endmodule

// File: tb/tb_scalar_bitcount_unit.sv
// Scoreboard bench for scalar_bitcount_unit: reference model, expected-result queue, monitor.
module tb_scalar_bitcount_unit;

  localparam int DW  = 64;
  localparam int RW  = 24;
  localparam int DSW = 3;
  localparam int PL  = 4;
  localparam int SL  = 3;

  logic           clk, rst, i_valid;
  logic [1:0]     i_op;
  logic [DW-1:0]  i_sj;
  logic [DSW-1:0] i_dest;
  logic           o_short_ready, o_valid;
  logic [RW-1:0]  o_result;
  logic [DSW-1:0] o_dest;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int             at;
    logic [RW-1:0]  res;
    logic [DSW-1:0] dest;
  } exp_t;

  exp_t sb[$];
  bit   pop_at[int];

  scalar_bitcount_unit #(
    .DATA_W    (DW),
    .GROUP_W   (8),
    .RES_W     (RW),
    .DEST_W    (DSW),
    .POP_LAT   (PL),
    .SHORT_LAT (SL)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_op          (i_op),
    .i_sj          (i_sj),
    .i_dest        (i_dest),
    .o_short_ready (o_short_ready),
    .o_valid       (o_valid),
    .o_result      (o_result),
    .o_dest        (o_dest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written from the op definitions, bit by bit.
  function automatic int model(input int op, input logic [DW-1:0] x);
    int n;
    n = 0;
    case (op)
      0: n = $countones(x);
      1: while (n < DW && !x[DW-1-n]) n++;
`ifdef SCALAR_BITCOUNT_TZ_EN
      2: while (n < DW && !x[n]) n++;
`else
      2: n = 0;
`endif
      default: n = $countones(x) % 2;
    endcase
    return n;
  endfunction

  // Drive one cycle of stimulus; the model decides acceptance and the completion cycle.
  task automatic issue(input bit v, input int op, input logic [DW-1:0] x, input int d);
    bit exp_ready, acc;
    exp_t e;
    @(negedge clk);
    i_valid   = v;
    i_op      = 2'(op);
    i_sj      = x;
    i_dest    = DSW'(d);
    exp_ready = !pop_at.exists(cyc + 1 - (PL - SL));
    if (v) check("short_ready", 64'(o_short_ready), 64'(exp_ready));
    acc = v && (op == 0 || exp_ready);
    if (acc) begin
      if (op == 0) pop_at[cyc + 1] = 1'b1;
      e.at   = cyc + ((op == 0) ? PL : SL);
      e.res  = RW'(model(op, x));
      e.dest = DSW'(d);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every presented result must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got result %0h dest %0d, expected no result (cycle %0d)",
                 o_result, o_dest, cyc);
      end else begin
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.at));
        check("result", 64'(o_result), 64'(e.res));
        check("dest", 64'(o_dest), 64'(e.dest));
      end
    end
  end

  logic [DW-1:0] x;

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = '0;
    i_sj    = '0;
    i_dest  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_dest", 64'(o_dest), 64'd0);
    check("rst_ready", 64'(o_short_ready), 64'd1);

    // POP sweep, spaced
    issue(1, 0, 64'h0, 1);                     idle(4);
    issue(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2);   idle(4);
    issue(1, 0, 64'h8000_0000_0000_0001, 3);   idle(4);
    // LZ/TZ boundaries
    issue(1, 1, 64'h0000_0100_0000_0000, 4);
    issue(1, 2, 64'h0000_0100_0000_0000, 5);
    issue(1, 1, 64'h0, 6);
    issue(1, 2, 64'h0, 7);
    issue(1, 1, 64'h1, 0);
    issue(1, 2, 64'h1, 1);
    issue(1, 2, 64'h10, 2);
    issue(1, 1, 64'h8000_0000_0000_0000, 3);
    issue(1, 2, 64'h8000_0000_0000_0000, 4);
    drain();

    // Hazard: LZ right behind a POP is refused, retry lands one cycle after the POP result
    idle(2);
    issue(1, 0, 64'hF0F0, 1);
    issue(1, 1, 64'h1234, 2);
    issue(1, 1, 64'h1234, 2);
    drain();

    // Streaming alternating LZ / PARITY
    for (int i = 0; i < 16; i++) begin
      x = (i % 4 == 1) ? 64'h7 : {$urandom, $urandom};
      issue(1, (i % 2 == 0) ? 1 : 3, x, i % 8);
    end
    drain();

    // Randomized mix with assorted operand shapes
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       x = {$urandom, $urandom};
        1:       x = 64'h1 << $urandom_range(0, 63);
        2:       x = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        3:       x = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: x = ($urandom_range(0, 1) == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      issue($urandom_range(0, 9) < 8, $urandom_range(0, 3), x, $urandom_range(0, 7));
    end
    drain();

    // Reset mid-flight: the POP accepted just before the pulse must never appear
    idle(3);
    issue(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    sb.delete();
    pop_at.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_result", 64'(o_result), 64'd0);
    check("midrst_dest", 64'(o_dest), 64'd0);
    check("midrst_ready", 64'(o_short_ready), 64'd1);
    idle(8);
    check("midrst_quiet", 64'(o_valid), 64'd0);

    // Short op straight after reset still works
    issue(1, 3, 64'h7, 6);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
